// File: rtl/vend_audio_pkg.sv
// Shared constants for the vending tone sequencer: note codes, melody IDs, the
// melody ROM and the note-to-half-period mapping.
package vend_audio_pkg;

   localparam logic [2:0] NOTE_END = 3'd0;
   localparam logic [2:0] NOTE_C5  = 3'd1;
   localparam logic [2:0] NOTE_E5  = 3'd2;
   localparam logic [2:0] NOTE_G5  = 3'd3;
   localparam logic [2:0] NOTE_C6  = 3'd4;
   localparam logic [2:0] NOTE_A3  = 3'd5;

   localparam logic [1:0] MEL_COIN   = 2'd0;
   localparam logic [1:0] MEL_VEND   = 2'd1;
   localparam logic [1:0] MEL_CHANGE = 2'd2;
   localparam logic [1:0] MEL_ERROR  = 2'd3;

   typedef enum logic [1:0] {StIdle, StTone, StGap} state_e;

   // Indexed [melody_id][slot]; NOTE_END terminates a melody early.
   localparam logic [2:0] MELODY_ROM [4][4] = '{
      '{NOTE_G5, NOTE_END, NOTE_END, NOTE_END},
      '{NOTE_C5, NOTE_E5,  NOTE_G5,  NOTE_C6 },
      '{NOTE_E5, NOTE_C5,  NOTE_END, NOTE_END},
      '{NOTE_A3, NOTE_A3,  NOTE_END, NOTE_END}
   };

   function automatic int unsigned half_period(input logic [2:0] code,
                                               input int unsigned clk_hz,
                                               input int unsigned tone_div);
      case (code)
         NOTE_C5: return clk_hz / (2 * 523) / tone_div;
         NOTE_E5: return clk_hz / (2 * 659) / tone_div;
         NOTE_G5: return clk_hz / (2 * 784) / tone_div;
         NOTE_C6: return clk_hz / (2 * 1047) / tone_div;
         NOTE_A3: return clk_hz / (2 * 220) / tone_div;
         default: return 0;
      endcase
   endfunction

   // Priority rank: error > vend > change > coin.
   function automatic logic [1:0] mel_prio(input logic [1:0] mel);
      case (mel)
         MEL_ERROR:  return 2'd3;
         MEL_VEND:   return 2'd2;
         MEL_CHANGE: return 2'd1;
         default:    return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_square_gen.sv
// Square-wave generator: toggles every half_i cycles while enabled, low otherwise.
module vend_square_gen #(
   parameter int unsigned HpW = 18
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           en_i,
   input  logic           restart_i,
   input  logic [HpW-1:0] half_i,
   output logic           sq_o
);

   logic [HpW-1:0] cnt_q, cnt_d;
   logic [HpW-1:0] hp_q, hp_d;
   logic           sq_q, sq_d;

   always_comb begin
      cnt_d = cnt_q;
      hp_d  = hp_q;
      sq_d  = sq_q;
      if (restart_i) begin
         hp_d  = half_i;
         cnt_d = half_i - HpW'(1);
         sq_d  = 1'b0;
      end else if (en_i) begin
         if (cnt_q == '0) begin
            sq_d  = ~sq_q;
            cnt_d = hp_q - HpW'(1);
         end else begin
            cnt_d = cnt_q - HpW'(1);
         end
      end else begin
         sq_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         hp_q  <= '0;
         sq_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         hp_q  <= hp_d;
         sq_q  <= sq_d;
      end
   end

   assign sq_o = sq_q;

endmodule

// File: rtl/vend_tone_sequencer.sv
// Turns vending event pulses into short square-wave melodies for the Pmod AMP2.
// Define VEND_TONE_QUEUE_EN to keep one dropped lower/equal-priority event pending.
module vend_tone_sequencer
   import vend_audio_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 100_000_000,
   parameter int unsigned NOTE_CYCLES = 10_000_000,
   parameter int unsigned GAP_CYCLES  = 1_000_000,
   parameter int unsigned TONE_DIV    = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ev_coin_i,
   input  logic       ev_vend_i,
   input  logic       ev_change_i,
   input  logic       ev_error_i,
   input  logic       mute_i,
   output logic       busy_o,
   output logic [1:0] melody_id_o,
   output logic       aud_pwm_o,
   output logic       aud_sd_o
);

   localparam int unsigned HP_W    = $clog2(half_period(NOTE_A3, CLK_HZ, 1));
   localparam int unsigned DUR_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
   localparam int unsigned DUR_W   = $clog2(DUR_MAX + 1);
   localparam logic [DUR_W-1:0] NOTE_LOAD = DUR_W'(NOTE_CYCLES - 1);
   localparam logic [DUR_W-1:0] GAP_LOAD  = DUR_W'(GAP_CYCLES - 1);

   state_e           state_q, state_d;
   logic [1:0]       mel_q, mel_d;
   logic [1:0]       slot_q, slot_d;
   logic [DUR_W-1:0] dur_q, dur_d;
   logic             aud_sd_q;
   logic             ev_any, preempt, restart, start, sq;
   logic [1:0]       ev_mel, start_mel, next_slot;
   logic [2:0]       tone_code, next_code;
`ifdef VEND_TONE_QUEUE_EN
   logic             pend_valid_q, pend_valid_d;
   logic [1:0]       pend_mel_q, pend_mel_d;
`endif

   always_comb begin
      ev_any = ev_error_i | ev_vend_i | ev_change_i | ev_coin_i;
      if (ev_error_i)       ev_mel = MEL_ERROR;
      else if (ev_vend_i)   ev_mel = MEL_VEND;
      else if (ev_change_i) ev_mel = MEL_CHANGE;
      else                  ev_mel = MEL_COIN;
   end

   assign preempt   = ev_any && (mel_prio(ev_mel) > mel_prio(mel_q));
   assign next_slot = slot_q + 2'd1;
   // Slot 3 is always the last note, so the pointer never wraps.
   assign next_code = (slot_q == 2'd3) ? NOTE_END : MELODY_ROM[mel_q][next_slot];

   always_comb begin
      state_d   = state_q;
      mel_d     = mel_q;
      slot_d    = slot_q;
      dur_d     = dur_q;
      restart   = 1'b0;
      start     = 1'b0;
      start_mel = ev_mel;
      tone_code = MELODY_ROM[mel_q][slot_q];
`ifdef VEND_TONE_QUEUE_EN
      pend_valid_d = pend_valid_q;
      pend_mel_d   = pend_mel_q;
`endif
      unique case (state_q)
         StIdle: start = ev_any;
         StTone, StGap: begin
            if (preempt) begin
               start = 1'b1;
            end else if (dur_q != '0) begin
               dur_d = dur_q - DUR_W'(1);
            end else if (state_q == StTone) begin
               state_d = StGap;
               dur_d   = GAP_LOAD;
            end else if (next_code != NOTE_END) begin
               slot_d    = next_slot;
               state_d   = StTone;
               dur_d     = NOTE_LOAD;
               restart   = 1'b1;
               tone_code = next_code;
`ifdef VEND_TONE_QUEUE_EN
            end else if (pend_valid_q) begin
               start        = 1'b1;
               start_mel    = pend_mel_q;
               pend_valid_d = 1'b0;
`endif
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (start) begin
         mel_d     = start_mel;
         slot_d    = 2'd0;
         state_d   = StTone;
         dur_d     = NOTE_LOAD;
         restart   = 1'b1;
         tone_code = MELODY_ROM[start_mel][0];
      end

`ifdef VEND_TONE_QUEUE_EN
      // Keep the strongest event that could not preempt the running melody.
      if (ev_any && (state_q != StIdle) && !preempt &&
          (!pend_valid_d || (mel_prio(ev_mel) > mel_prio(pend_mel_d)))) begin
         pend_valid_d = 1'b1;
         pend_mel_d   = ev_mel;
      end
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         mel_q    <= MEL_COIN;
         slot_q   <= 2'd0;
         dur_q    <= '0;
         aud_sd_q <= 1'b1;
`ifdef VEND_TONE_QUEUE_EN
         pend_valid_q <= 1'b0;
         pend_mel_q   <= MEL_COIN;
`endif
      end else begin
         state_q  <= state_d;
         mel_q    <= mel_d;
         slot_q   <= slot_d;
         dur_q    <= dur_d;
         aud_sd_q <= ~mute_i;
`ifdef VEND_TONE_QUEUE_EN
         pend_valid_q <= pend_valid_d;
         pend_mel_q   <= pend_mel_d;
`endif
      end
   end

   vend_square_gen #(
      .HpW(HP_W)
   ) u_square (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (state_q == StTone),
      .restart_i(restart),
      .half_i   (HP_W'(half_period(tone_code, CLK_HZ, TONE_DIV))),
      .sq_o     (sq)
   );

   assign busy_o      = (state_q != StIdle);
   assign melody_id_o = mel_q;
   assign aud_pwm_o   = sq & (state_q == StTone) & ~mute_i;
   assign aud_sd_o    = aud_sd_q;

endmodule

// File: tb/tb_vend_tone_sequencer.sv
// Directed bench for vend_tone_sequencer with shortened notes and divided tones.
module tb_vend_tone_sequencer;

   localparam int NOTE = 2000;
   localparam int GAP  = 200;
   localparam int SLOT = NOTE + GAP;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ev_coin = 1'b0, ev_vend = 1'b0, ev_change = 1'b0, ev_error = 1'b0;
   logic       mute = 1'b0;
   logic       busy, aud_pwm, aud_sd;
   logic [1:0] melody_id;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vend_tone_sequencer #(
      .CLK_HZ     (100_000_000),
      .NOTE_CYCLES(NOTE),
      .GAP_CYCLES (GAP),
      .TONE_DIV   (1000)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .ev_coin_i  (ev_coin),
      .ev_vend_i  (ev_vend),
      .ev_change_i(ev_change),
      .ev_error_i (ev_error),
      .mute_i     (mute),
      .busy_o     (busy),
      .melody_id_o(melody_id),
      .aud_pwm_o  (aud_pwm),
      .aud_sd_o   (aud_sd)
   );

   // Called at a negedge; ev = {error, vend, change, coin}. Returns at the negedge
   // following the sampling posedge (cycle k=0 of the melody).
   task automatic pulse(input logic [3:0] ev);
      {ev_error, ev_vend, ev_change, ev_coin} = ev;
      @(negedge clk);
      {ev_error, ev_vend, ev_change, ev_coin} = 4'b0000;
   endtask

   // Compares ncyc negedge samples against the expected note sequence; optionally
   // pulses ev_coin at cycle inj.
   task automatic observe(input int hp [5], input int mel [5], input int n, input int ncyc,
                          input bit muted, input int inj,
                          output int bad_pwm, output int bad_busy, output int bad_mel);
      bad_pwm = 0;
      bad_busy = 0;
      bad_mel = 0;
      for (int k = 0; k < ncyc; k++) begin
         int   idx;
         int   off;
         logic exp_pwm;
         logic exp_busy;
         idx = k / SLOT;
         off = k % SLOT;
         exp_busy = (idx < n);
         exp_pwm = 1'b0;
         if (idx < n && off < NOTE && !muted) exp_pwm = ((off / hp[idx]) % 2) == 1;
         if (aud_pwm !== exp_pwm) bad_pwm++;
         if (busy !== exp_busy) bad_busy++;
         if (idx < n && melody_id !== 2'(mel[idx])) bad_mel++;
         ev_coin = (k == inj);
         @(negedge clk);
      end
      ev_coin = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy: actual=%0b required=0", busy);
      end
      checks++;
      if (melody_id !== 2'd0) begin
         failures++;
         $display("FAIL reset_melody_id: actual=%0d required=0", melody_id);
      end
      checks++;
      if (aud_pwm !== 1'b0) begin
         failures++;
         $display("FAIL reset_aud_pwm: actual=%0b required=0", aud_pwm);
      end
      checks++;
      if (aud_sd !== 1'b1) begin
         failures++;
         $display("FAIL reset_aud_sd: actual=%0b required=1", aud_sd);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_coin();
      int bp, bb, bm;
      pulse(4'b0001);
      observe('{63, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, 1, SLOT + 1, 1'b0, -1, bp, bb, bm);
      checks++;
      if (bp !== 0) begin
         failures++;
         $display("FAIL coin_pwm: bad_cycles=%0d required=0", bp);
      end
      checks++;
      if (bb !== 0) begin
         failures++;
         $display("FAIL coin_busy: bad_cycles=%0d required=0", bb);
      end
      checks++;
      if (bm !== 0) begin
         failures++;
         $display("FAIL coin_melody_id: bad_cycles=%0d required=0", bm);
      end
   endtask

   task automatic test_vend();
      int bp, bb, bm;
      pulse(4'b0100);
      observe('{95, 75, 63, 47, 0}, '{1, 1, 1, 1, 0}, 4, 4 * SLOT + 1, 1'b0, -1, bp, bb, bm);
      checks++;
      if (bp !== 0) begin
         failures++;
         $display("FAIL vend_pwm: bad_cycles=%0d required=0", bp);
      end
      checks++;
      if (bb !== 0) begin
         failures++;
         $display("FAIL vend_busy: bad_cycles=%0d required=0", bb);
      end
      checks++;
      if (melody_id !== 2'd1 || bm !== 0) begin
         failures++;
         $display("FAIL vend_melody_id: actual=%0d bad_cycles=%0d required=1", melody_id, bm);
      end
   endtask

   task automatic test_simultaneous();
      int bp, bb, bm;
      pulse(4'b1001);
      observe('{227, 227, 0, 0, 0}, '{3, 3, 0, 0, 0}, 2, 2 * SLOT + 1, 1'b0, -1, bp, bb, bm);
      checks++;
      if (bp !== 0) begin
         failures++;
         $display("FAIL simul_pwm: bad_cycles=%0d required=0", bp);
      end
      checks++;
      if (bb !== 0) begin
         failures++;
         $display("FAIL simul_busy: bad_cycles=%0d required=0", bb);
      end
      checks++;
      if (bm !== 0) begin
         failures++;
         $display("FAIL simul_melody_id: bad_cycles=%0d required=0", bm);
      end
   endtask

   task automatic test_preempt();
      int bp, bb, bm;
      pulse(4'b0100);
      observe('{95, 75, 63, 47, 0}, '{1, 1, 1, 1, 0}, 4, 500, 1'b0, -1, bp, bb, bm);
      checks++;
      if (bp !== 0 || bb !== 0 || bm !== 0) begin
         failures++;
         $display("FAIL preempt_vend_prefix: bad_pwm=%0d bad_busy=%0d bad_mel=%0d required=0",
                  bp, bb, bm);
      end
      pulse(4'b1000);
`ifdef VEND_TONE_QUEUE_EN
      observe('{227, 227, 63, 0, 0}, '{3, 3, 0, 0, 0}, 3, 3 * SLOT + 1, 1'b0, 1000, bp, bb, bm);
`else
      observe('{227, 227, 0, 0, 0}, '{3, 3, 0, 0, 0}, 2, 2 * SLOT + 1, 1'b0, 1000, bp, bb, bm);
`endif
      checks++;
      if (bp !== 0) begin
         failures++;
         $display("FAIL preempt_pwm: bad_cycles=%0d required=0", bp);
      end
      checks++;
      if (bb !== 0) begin
         failures++;
         $display("FAIL preempt_busy: bad_cycles=%0d required=0", bb);
      end
      checks++;
      if (bm !== 0) begin
         failures++;
         $display("FAIL preempt_melody_id: bad_cycles=%0d required=0", bm);
      end
   endtask

   task automatic test_mute();
      int bp, bb, bm;
      mute = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (aud_sd !== 1'b0) begin
         failures++;
         $display("FAIL mute_aud_sd: actual=%0b required=0", aud_sd);
      end
      pulse(4'b0100);
      observe('{95, 75, 63, 47, 0}, '{1, 1, 1, 1, 0}, 4, 4 * SLOT + 1, 1'b1, -1, bp, bb, bm);
      checks++;
      if (bp !== 0) begin
         failures++;
         $display("FAIL mute_pwm: bad_cycles=%0d required=0", bp);
      end
      checks++;
      if (bb !== 0) begin
         failures++;
         $display("FAIL mute_busy: bad_cycles=%0d required=0", bb);
      end
      mute = 1'b0;
      @(negedge clk);
      checks++;
      if (aud_sd !== 1'b1) begin
         failures++;
         $display("FAIL unmute_aud_sd: actual=%0b required=1", aud_sd);
      end
   endtask

   task automatic test_reset_mid();
      int bp, bb, bm;
      pulse(4'b0100);
      observe('{95, 75, 63, 47, 0}, '{1, 1, 1, 1, 0}, 4, 300, 1'b0, -1, bp, bb, bm);
      checks++;
      if (aud_pwm !== 1'b1) begin
         failures++;
         $display("FAIL midreset_pre_pwm: actual=%0b required=1", aud_pwm);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || aud_pwm !== 1'b0) begin
         failures++;
         $display("FAIL midreset_async: busy=%0b pwm=%0b required=0,0", busy, aud_pwm);
      end
      checks++;
      if (aud_sd !== 1'b1 || melody_id !== 2'd0) begin
         failures++;
         $display("FAIL midreset_sd_mel: sd=%0b mel=%0d required=1,0", aud_sd, melody_id);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pulse(4'b0100);
      observe('{95, 75, 63, 47, 0}, '{1, 1, 1, 1, 0}, 4, 4 * SLOT + 1, 1'b0, -1, bp, bb, bm);
      checks++;
      if (bp !== 0 || bb !== 0 || bm !== 0) begin
         failures++;
         $display("FAIL midreset_restart: bad_pwm=%0d bad_busy=%0d bad_mel=%0d required=0",
                  bp, bb, bm);
      end
   endtask

   initial begin
      test_reset();
      test_coin();
      test_vend();
      test_simultaneous();
      test_preempt();
      test_mute();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vend_tone_sequencer.md
Name: vend_tone_sequencer

Overview:
- Audio stage downstream of the vending controller core; drives the Pmod AMP2 on JA.
- Converts single-cycle event pulses (coin accepted, vend, change returned, error) into short square-wave melodies.
- Melodies are read from a fixed note ROM; output is the 1-bit aud_pwm plus the aud_sd amplifier enable.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; used to derive tone half-periods.
- NOTE_CYCLES, 10_000_000, length of each note in clk cycles (100 ms).
- GAP_CYCLES, 1_000_000, silent gap after every note (10 ms).
- TONE_DIV, 1, integer divisor applied to all half-period counts; raised in simulation only.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ev_coin  in  1  one-cycle pulse: coin accepted.
- ev_vend  in  1  one-cycle pulse: purchase succeeded.
- ev_change  in  1  one-cycle pulse: change returned.
- ev_error  in  1  one-cycle pulse: invalid purchase or out of stock.
- mute  in  1  level: silences output; sequencing continues.
- busy  out  1  high while a melody is active.
- melody_id  out  2  melody playing: 0 coin, 1 vend, 2 change, 3 error.
- aud_pwm  out  1  square-wave audio.
- aud_sd  out  1  amplifier enable (active-low shutdown pin); 1 = amp on.

Behaviour:
- Reset values: busy=0, melody_id=0, aud_pwm=0, aud_sd=1. FSM is in IDLE with all counters cleared.
- Reset asserted mid-melody aborts it immediately.
- Event priority, highest first: error, vend, change, coin. Simultaneous pulses select the highest; the others are dropped.
- Melodies, with half-period = CLK_HZ/(2*f)/TONE_DIV, integer-truncated:
  - coin: G5 (784 Hz).
  - vend: C5 523, E5 659, G5 784, C6 1047.
  - change: E5, C5.
  - error: A3 220, A3.
- ROM: 4 melodies x 4 slots of 3-bit note codes; code 0 is the end marker.
- FSM IDLE:
  - An event pulse sampled on edge N loads melody_id and slot 0.
  - Goes to TONE; busy=1 from edge N+1.
- FSM TONE:
  - Half-period counter counts down; each expiry toggles the square wave. The first toggle occurs one half-period after entry.
  - Duration counter runs NOTE_CYCLES cycles, then goes to GAP.
- FSM GAP:
  - Square wave forced low for GAP_CYCLES cycles.
  - Then slot increments. Go to TONE if the next code is nonzero, else IDLE.
  - Slot 3 is always last, so the slot pointer never wraps.
- Returning to IDLE: busy falls on the edge that enters IDLE; melody_id holds its last value.
- Preemption:
  - A strictly higher-priority event during TONE or GAP restarts at slot 0 of the new melody on the next edge.
  - All counters reload, the square wave resets low, and busy stays high throughout.
  - Equal or lower priority events are dropped (see optional feature).
- Output: aud_pwm = square wave AND (state==TONE) AND NOT mute. aud_sd = NOT mute, registered.
- Width rules:
  - Half-period counter: clog2 of the A3 count at TONE_DIV=1, 18 bits at 100 MHz.
  - Duration counter: clog2(NOTE_CYCLES+1) bits.

Optional Feature:
- Macro: VEND_TONE_QUEUE_EN.
- Defined:
  - A one-entry pending register captures a dropped event of equal or lower priority, keeping the highest such event.
  - On melody completion the FSM goes straight to TONE for the pending melody; busy stays high and the pending entry clears.
  - Reset clears the pending entry.
- Undefined: such events are discarded; no pending register exists.

Decomposition:
- Package vend_audio_pkg holds:
  - note code constants (NOTE_END, NOTE_C5, NOTE_E5, NOTE_G5, NOTE_C6, NOTE_A3);
  - melody ID constants (MEL_COIN, MEL_VEND, MEL_CHANGE, MEL_ERROR);
  - a function returning half-period for a note code, given CLK_HZ and TONE_DIV;
  - the 4x4 melody ROM contents.
- One sub-module, vend_square_gen: enable, half-period load, restart, square out.

Test Plan:
- Set TONE_DIV=1000, NOTE_CYCLES=2000, GAP_CYCLES=200.
- Reset: assert rst mid-vend melody -> aud_pwm=0, busy=0, aud_sd=1 asynchronously; the next event starts at slot 0.
- Coin: pulse ev_coin -> busy=1 next edge; aud_pwm toggles every 63 cycles (G5) for 2000 cycles; low 200 cycles; busy=0 after 2200 cycles.
- Vend sequence: pulse ev_vend -> four tones with half-periods 95, 75, 63, 47, each separated by 200 low cycles; total busy 8800 cycles; melody_id=1.
- Simultaneous events: ev_coin and ev_error in the same cycle -> melody_id=3; half-period 227; coin never heard.
- Preemption: ev_error 500 cycles into vend -> restart at A3 on the next edge. ev_coin during error -> ignored without macro; with VEND_TONE_QUEUE_EN, the coin melody plays after error finishes with no busy gap.
- Mute: hold mute during vend -> aud_pwm=0, aud_sd=0, busy timing unchanged (8800 cycles).
